mm_bram_port_arbiter: RTL
=========================

// Module: mm_bram_port_arbiter
// PURPOSE
//  Shares the single BRAM port of the Montgomery multiplier subsystem between two requesters.
//  r0 is the MM core; r1 is the operand loader/unloader.
//  Round-robin ownership with bus lock and anti-starvation hold limit.
//  Tags reads through the BRAM pipeline so every read returns to the requester that issued it.
//  Sits between the requesters and the BRAM master port; the wrapper does the byte-address shift.
// PARAMETERS
//  ADDR_WIDTH    32  word address width
//  DATA_WIDTH    17  data width; one 17-bit limb per BRAM word
//  READ_LATENCY  2   cycles from BRAM_en_o high (read) to valid BRAM_dout_i; range 1..4
//  MAX_HOLD      64  max cycles an unlocked owner keeps the port while the other requests; 0 = no limit
// PORTS
//  clock_i      in   1           system clock
//  reset_i      in   1           asynchronous, active-high reset
//  rN_req_i     in   1           N=0,1: requester wants the port / issues an access this cycle
//  rN_lock_i    in   1           keep ownership even if rN_req_i drops (burst); suppresses forced release
//  rN_we_i      in   1           1 = write, 0 = read
//  rN_addr_i    in   ADDR_WIDTH  word address
//  rN_din_i     in   DATA_WIDTH  write data
//  rN_gnt_o     out  1           registered: rN owns the port
//  rN_rvalid_o  out  1           rN_dout_o carries read data for an rN read
//  rN_dout_o    out  DATA_WIDTH  = BRAM_dout_i (broadcast; qualify with rvalid)
//  BRAM_en_o    out  1           registered BRAM enable
//  BRAM_we_o    out  1           registered write enable (wrapper replicates to bytes)
//  BRAM_addr_o  out  ADDR_WIDTH  registered address
//  BRAM_din_o   out  DATA_WIDTH  registered write data
//  BRAM_dout_i  in   DATA_WIDTH  BRAM read data
// BEHAVIOUR
//  - Reset values:
//    - All outputs 0; state IDLE; hold counter 0; read-tag pipe cleared.
//    - last_served=1, so r0 wins the first tie.
//    - Reset mid-operation drops in-flight reads: no rvalid is produced for them.
//  - FSM states: IDLE, OWN0, OWN1. gnt_o is decoded from state (OWN0 -> r0_gnt_o, OWN1 -> r1_gnt_o).
//  - IDLE:
//    - Only one requester's req high -> go to its OWN state.
//    - Both high -> grant the requester != last_served.
//    - One-cycle bubble: the grant is visible the cycle after the request.
//  - OWNx:
//    - Access accepted in any cycle with rx_req_i & rx_gnt_o.
//    - Accepted access: BRAM_en_o=1 next cycle, with we/addr/din registered from rx.
//    - Otherwise BRAM_en_o=0 next cycle.
//  - Release of OWNx happens when either:
//    (a) rx_req_i=0 and rx_lock_i=0; or
//    (b) MAX_HOLD!=0, ry_req_i=1, rx_lock_i=0, and hold counter == MAX_HOLD-1.
//  - On release: last_served<=x; next state OWNy if ry_req_i else IDLE (handover, no bubble).
//  - Access on the release cycle:
//    - (b): the rx access in the release cycle is still accepted.
//    - (a): there is no access.
//  - Hold counter:
//    - Increments in OWNx while ry_req_i=1; clears on any state change.
//    - Saturates; lock high freezes it at its value.
//  - Read tagging:
//    - Shift register of READ_LATENCY+1 stages holding {valid, id}.
//    - Loaded with {accepted & ~we, x} at acceptance.
//    - At the output, rid_rvalid_o = 1 for exactly one cycle, aligned with valid BRAM_dout_i.
//    - Read accepted at cycle t -> rvalid at t+1+READ_LATENCY.
//    - Returns complete correctly across ownership changes.
//  - Writes produce no rvalid.
//  - Back-to-back accesses sustain 1/cycle; no gaps within ownership.
//  - Never two grants at once; BRAM_en_o only ever reflects a granted requester.
// TESTING
//  1. Reset, r0 reads addr 5,6,7 back-to-back (BRAM preloaded 5->0x1AAAA, 6->0x00001, 7->0x1FFFF)
//     -> r0_gnt_o at cycle 1; r0_rvalid_o at cycles 4,5,6 (LATENCY=2) with those values;
//     r1_rvalid_o never set.
//  2. r0 and r1 req in the same cycle from IDLE after reset -> r0 granted first.
//     After r0 drops req -> OWN1 next cycle with no IDLE bubble.
//     Next tie -> r1 loses (round-robin).
//  3. MAX_HOLD=4, r0 streams continuously unlocked, r1 requests
//     -> r0_gnt_o drops after 4 cycles of r1 waiting; r1_gnt_o rises next cycle.
//     Repeat with r0_lock_i=1 -> r0 keeps the port indefinitely.
//  4. r1 issues read to addr 9 on its release cycle, r0 takes over and writes addr 9 = 0x12345
//     -> r1_rvalid_o returns the old value; r0_rvalid_o stays 0.
//     A subsequent r0 read of addr 9 returns 0x12345.
//  5. Assert reset_i asynchronously with two reads in flight -> all outputs 0 immediately.
//     No rvalid afterwards; first post-reset tie goes to r0.
//  6. Random req/lock/we on both ports for 10k cycles with a scoreboard BRAM model
//     -> every read returns to its issuer with model data; gnt one-hot-or-zero every cycle.

Source files
------------

// File: rtl/mm_bram_port_arbiter.sv
// Arbiter sharing the Montgomery multiplier's single BRAM port between the MM core (r0)
// and the operand loader (r1): round-robin with lock, hold limit, and tagged read returns.
module mm_bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 17,
  parameter int READ_LATENCY = 2,
  parameter int MAX_HOLD     = 64
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  r0_req_i,
  input  logic                  r0_lock_i,
  input  logic                  r0_we_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_din_i,
  output logic                  r0_gnt_o,
  output logic                  r0_rvalid_o,
  output logic [DATA_WIDTH-1:0] r0_dout_o,
  input  logic                  r1_req_i,
  input  logic                  r1_lock_i,
  input  logic                  r1_we_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_din_i,
  output logic                  r1_gnt_o,
  output logic                  r1_rvalid_o,
  output logic [DATA_WIDTH-1:0] r1_dout_o,
  output logic                  BRAM_en_o,
  output logic                  BRAM_we_o,
  output logic [ADDR_WIDTH-1:0] BRAM_addr_o,
  output logic [DATA_WIDTH-1:0] BRAM_din_o,
  input  logic [DATA_WIDTH-1:0] BRAM_dout_i
);

  // One-hot owner encoding lets each grant come straight off a state flop.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  localparam int            HW        = $clog2(MAX_HOLD + 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  localparam bit            HOLD_EN   = (MAX_HOLD != 0);

  state_t                state;
  logic                  last_served;
  logic [HW-1:0]         hold_cnt;
  logic [READ_LATENCY:0] tag_vld;
  logic [READ_LATENCY:0] tag_id;

  logic                  owner;
  logic                  cur_req;
  logic                  cur_lock;
  logic                  cur_we;
  logic                  oth_req;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_din;
  logic                  accept;
  logic                  release_now;

  always_comb begin
    owner       = state[1];
    cur_req     = owner ? r1_req_i  : r0_req_i;
    cur_lock    = owner ? r1_lock_i : r0_lock_i;
    cur_we      = owner ? r1_we_i   : r0_we_i;
    cur_addr    = owner ? r1_addr_i : r0_addr_i;
    cur_din     = owner ? r1_din_i  : r0_din_i;
    oth_req     = owner ? r0_req_i  : r1_req_i;
    accept      = (state != IDLE) && cur_req;
    // A forced release still accepts the owner's access; a voluntary one has none.
    release_now = (state != IDLE) && !cur_lock &&
                  (!cur_req || (HOLD_EN && oth_req && hold_cnt == HOLD_LAST));
  end

  // NOTE: all state below updates with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      last_served <= 1'b1;
      hold_cnt    <= '0;
      tag_vld     <= '0;
      tag_id      <= '0;
      BRAM_en_o   <= 1'b0;
      BRAM_we_o   <= 1'b0;
      BRAM_addr_o <= '0;
      BRAM_din_o  <= '0;
    end else begin
      BRAM_en_o <= accept;
      BRAM_we_o <= accept && cur_we;
      if (accept) begin
        BRAM_addr_o <= cur_addr;
        BRAM_din_o  <= cur_din;
      end
      tag_vld <= {tag_vld[READ_LATENCY-1:0], accept && !cur_we};
      tag_id  <= {tag_id[READ_LATENCY-1:0], owner};

      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (r0_req_i && (!r1_req_i || last_served)) state <= OWN0;
          else if (r1_req_i)                          state <= OWN1;
        end
        OWN0, OWN1: begin
          if (release_now) begin
            last_served <= owner;
            hold_cnt    <= '0;
            if (oth_req) state <= owner ? OWN0 : OWN1;
            else         state <= IDLE;
          end else if (oth_req && !cur_lock && hold_cnt != {HW{1'b1}}) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r0_gnt_o    = state[0];
  assign r1_gnt_o    = state[1];
  assign r0_rvalid_o = tag_vld[READ_LATENCY] && !tag_id[READ_LATENCY];
  assign r1_rvalid_o = tag_vld[READ_LATENCY] &&  tag_id[READ_LATENCY];
  assign r0_dout_o   = BRAM_dout_i;
  assign r1_dout_o   = BRAM_dout_i;

endmodule
